// File: rtl/audio_dac_stream_if.sv
// +----------------------------------------------------------------------------+
// | audio_dac_stream_if                                                        |
// | Sample-stream inputs and serial-DAC / status outputs of audio_dac_stream.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface audio_dac_stream_if;
    logic        enable;
    logic        sample_strobe;
    logic [7:0]  sample_in;
    logic        clear_overflow;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        dac_cs_n;
    logic        busy;
    logic        fifo_overflow;
    logic [15:0] frames_sent;

    modport master (
        output enable, sample_strobe, sample_in, clear_overflow,
        input  dac_sclk, dac_mosi, dac_cs_n, busy, fifo_overflow, frames_sent
    );

    modport slave (
        input  enable, sample_strobe, sample_in, clear_overflow,
        output dac_sclk, dac_mosi, dac_cs_n, busy, fifo_overflow, frames_sent
    );
endinterface

`default_nettype wire

// File: rtl/audio_dac_stream.sv
// +----------------------------------------------------------------------------+
// | audio_dac_stream                                                           |
// | Buffers strobed 8-bit samples and sends each as a 16-bit SPI DAC frame.    |
// | Optional macro AUDIO_DAC_MIDSCALE_PARK_EN: park frame (0x80) on disable.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module audio_dac_stream #(
    parameter int       SCLK_DIV   = 4,
    parameter int       FIFO_DEPTH = 4,
    parameter logic [3:0] DAC_CMD  = 4'b0011,
    parameter int       GAP_CYCLES = 8
) (
    input  wire logic          clock_50Mhz,
    input  wire logic          reset_n,
    audio_dac_stream_if.slave  bus
);

    localparam int              c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0]     c_DIV_LAST = 16'(SCLK_DIV - 1);
    localparam logic [15:0]     c_GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]      c_MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;
    logic              r_ovf;
    logic [15:0]       r_shift;
    logic [15:0]       r_div;
    logic [4:0]        r_half;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic [15:0]       r_frames_sent;

    logic w_park_want;
    logic w_push_req;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A pending park frame is served before any queued sample.
    assign w_pop      = (r_state == S_IDLE) && bus.enable && (r_count != '0) && !w_park_want;
    assign w_push_req = bus.sample_strobe && bus.enable;
    assign w_push     = w_push_req && ((r_count < c_DEPTH) || w_pop);
    assign w_drop     = w_push_req && !w_push;

`ifdef AUDIO_DAC_MIDSCALE_PARK_EN
    logic r_en_d;
    logic r_park_pend;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d      <= 1'b0;
            r_park_pend <= 1'b0;
        end else begin
            r_en_d      <= bus.enable;
            r_park_pend <= w_park_want && (r_state != S_IDLE);
        end
    end

    assign w_park_want = r_park_pend | (r_en_d & ~bus.enable);
`else
    assign w_park_want = 1'b0;
`endif

    always_ff @(posedge clock_50Mhz) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.sample_in;
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (!bus.enable) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)                  r_ovf <= 1'b1;
            else if (bus.clear_overflow) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_div         <= '0;
            r_half        <= '0;
            r_sclk        <= 1'b0;
            r_mosi        <= 1'b0;
            r_cs_n        <= 1'b1;
            r_frames_sent <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (w_park_want) begin
                        r_shift <= {DAC_CMD, c_MIDSCALE, 4'b0000};
                        r_state <= S_LOAD;
                    end else if (w_pop) begin
                        r_shift <= {DAC_CMD, r_mem[r_rptr], 4'b0000};
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // First LOAD cycle only asserts chip select; the setup hold follows.
                    if (r_cs_n) begin
                        r_cs_n <= 1'b0;
                        r_mosi <= r_shift[15];
                        r_div  <= '0;
                    end else if (r_div == c_DIV_LAST) begin
                        r_div   <= '0;
                        r_half  <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div  <= '0;
                        r_half <= r_half + 1'b1;
                        if (r_sclk) begin
                            r_sclk  <= 1'b0;
                            r_mosi  <= r_shift[14];
                            r_shift <= {r_shift[14:0], 1'b0};
                        end else if (r_half == 5'd31) begin
                            r_cs_n        <= 1'b1;
                            r_mosi        <= 1'b0;
                            r_frames_sent <= r_frames_sent + 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_sclk <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_div == c_GAP_LAST) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dac_sclk      = r_sclk;
    assign bus.dac_mosi      = r_mosi;
    assign bus.dac_cs_n      = r_cs_n;
    assign bus.fifo_overflow = r_ovf;
    assign bus.frames_sent   = r_frames_sent;
    assign bus.busy          = (r_state != S_IDLE) || (r_count != '0) || w_park_want;

endmodule

`default_nettype wire

// File: tb/tb_audio_dac_stream.sv
// +----------------------------------------------------------------------------+
// | tb_audio_dac_stream                                                        |
// | Self-checking bench: SPI frame monitor against a sample-queue model.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_audio_dac_stream;

    localparam int         SCLK_DIV   = 4;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [3:0] DAC_CMD    = 4'b0011;
    localparam int         GAP_CYCLES = 8;
    localparam int         FRAME_LEN  = SCLK_DIV * 33;

    logic clk;
    logic rst_n;
    audio_dac_stream_if bus ();

    audio_dac_stream #(
        .SCLK_DIV   (SCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DAC_CMD    (DAC_CMD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock_50Mhz (clk),
        .reset_n     (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_frames;
    logic        exp_ovf;
    logic [15:0] word_q[$];
    int          nbit_q[$];
    int          len_q[$];
    int          min_gap;
    logic [7:0]  bvals[8];

    // Frame monitor: decodes what a real DAC would latch on rising sclk.
    initial begin
        logic        prev_cs;
        logic        prev_sclk;
        logic        seen;
        int          nbits;
        int          lowc;
        int          highc;
        logic [15:0] sh;
        prev_cs = 1'b1; prev_sclk = 1'b0; seen = 1'b0;
        nbits = 0; lowc = 0; highc = 0; sh = '0;
        min_gap = 1 << 30;
        forever begin
            @(negedge clk);
            if (bus.dac_cs_n === 1'b0) begin
                if (prev_cs && seen && highc < 1000 && highc < min_gap) min_gap = highc;
                lowc++;
                if (bus.dac_sclk === 1'b1 && prev_sclk === 1'b0) begin
                    sh = {sh[14:0], bus.dac_mosi};
                    nbits++;
                end
            end else begin
                if (!prev_cs) begin
                    word_q.push_back(sh);
                    nbit_q.push_back(nbits);
                    len_q.push_back(lowc);
                    seen  = 1'b1;
                    highc = 0;
                end
                highc++;
                nbits = 0;
                lowc  = 0;
            end
            prev_cs   = bus.dac_cs_n;
            prev_sclk = bus.dac_sclk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] s);
        return {DAC_CMD, s, 4'b0000};
    endfunction

    task automatic pulse_strobe(input logic [7:0] v);
        @(posedge clk); #1;
        bus.sample_strobe = 1'b1;
        bus.sample_in     = v;
        @(posedge clk); #1;
        bus.sample_strobe = 1'b0;
    endtask

    // Back-to-back strobes from an idle engine: one goes straight to the
    // shifter, FIFO_DEPTH more are buffered, the rest are lost.
    task automatic burst(input int k, input bit clr_last);
        @(posedge clk); #1;
        for (int i = 0; i < k; i++) begin
            bus.sample_strobe  = 1'b1;
            bus.sample_in      = bvals[i];
            bus.clear_overflow = clr_last && (i == k - 1);
            if (i < FIFO_DEPTH + 1) begin
                exp_q.push_back(frame_of(bvals[i]));
                exp_frames++;
            end else begin
                exp_ovf = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.sample_strobe  = 1'b0;
        bus.clear_overflow = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 20000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, 32'(word_q.size()), 32'(exp_q.size()));
        while (word_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_word"}, 32'(word_q.pop_front()), 32'(exp_q.pop_front()));
            check({tag, "_bits"}, 32'(nbit_q.pop_front()), 32'd16);
            check({tag, "_len"},  32'(len_q.pop_front()),  32'(FRAME_LEN));
        end
        word_q.delete(); nbit_q.delete(); len_q.delete(); exp_q.delete();
        check({tag, "_frames_sent"}, 32'(bus.frames_sent), 32'(exp_frames));
        check({tag, "_overflow"},    32'(bus.fifo_overflow), 32'(exp_ovf));
    endtask

    initial begin
        int          n;
        logic [7:0]  v;
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.sample_strobe = 1'b0;
        bus.sample_in = '0; bus.clear_overflow = 1'b0;
        exp_frames = '0; exp_ovf = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cs_n",   32'(bus.dac_cs_n), 32'd1);
        check("rst_sclk",   32'(bus.dac_sclk), 32'd0);
        check("rst_mosi",   32'(bus.dac_mosi), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_ovf",    32'(bus.fifo_overflow), 32'd0);
        check("rst_frames", 32'(bus.frames_sent), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Strobes while disabled are ignored.
        pulse_strobe(8'h55);
        repeat (6) @(negedge clk);
        check("dis_busy", 32'(bus.busy), 32'd0);
        check("dis_ovf",  32'(bus.fifo_overflow), 32'd0);
        check("dis_cs_n", 32'(bus.dac_cs_n), 32'd1);

        // Single sample with latency check.
        @(posedge clk); #1 bus.enable = 1'b1;
        pulse_strobe(8'hA5);
        exp_q.push_back(16'h3A50); exp_frames++;
        @(negedge clk);
        @(negedge clk);
        check("lat_cs_n_n2", 32'(bus.dac_cs_n), 32'd1);
        @(negedge clk);
        check("lat_cs_n_n3", 32'(bus.dac_cs_n), 32'd0);
        wait_idle("single");
        check_frames("single");
        check("single_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a frame.
        pulse_strobe(8'($urandom));
        n = 0;
        while (bus.dac_sclk !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("midrst_reach_shift", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("midrst_cs_n_now", 32'(bus.dac_cs_n), 32'd1);
        check("midrst_sclk_now", 32'(bus.dac_sclk), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_frames", 32'(bus.frames_sent), 32'd0);
        check("midrst_busy",   32'(bus.busy), 32'd0);
        check("midrst_mosi",   32'(bus.dac_mosi), 32'd0);
        check("midrst_ovf",    32'(bus.fifo_overflow), 32'd0);
        word_q.delete(); nbit_q.delete(); len_q.delete(); exp_q.delete();
        exp_frames = '0;

        // Six back-to-back strobes: the sixth is lost.
        for (int i = 0; i < 6; i++) bvals[i] = 8'(i + 1);
        burst(6, 1'b0);
        @(negedge clk);
        check("burst6_ovf_set", 32'(bus.fifo_overflow), 32'd1);
        wait_idle("burst6");
        check_frames("burst6");
        @(posedge clk); #1 bus.clear_overflow = 1'b1;
        @(posedge clk); #1 bus.clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(bus.fifo_overflow), 32'd0);

        // Clear coinciding with a drop: the drop wins.
        for (int i = 0; i < 6; i++) bvals[i] = 8'($urandom);
        burst(6, 1'b1);
        @(negedge clk);
        check("ovf_clear_vs_drop", 32'(bus.fifo_overflow), 32'd1);
        wait_idle("clrdrop");
        check_frames("clrdrop");
        @(posedge clk); #1 bus.clear_overflow = 1'b1;
        @(posedge clk); #1 bus.clear_overflow = 1'b0;
        exp_ovf = 1'b0;

        // Random bursts that fit the buffering.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 8; i++) bvals[i] = 8'($urandom);
            burst(int'($urandom_range(1, FIFO_DEPTH + 1)), 1'b0);
            wait_idle("rburst");
        end
        check_frames("rburst");

        // Disable mid-frame with samples queued.
        for (int i = 0; i < 3; i++) bvals[i] = 8'($urandom);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.sample_strobe = 1'b1; bus.sample_in = bvals[i];
            @(posedge clk); #1;
        end
        bus.sample_strobe = 1'b0;
        exp_q.push_back(frame_of(bvals[0])); exp_frames++;
        repeat (40) @(negedge clk);
        @(posedge clk); #1 bus.enable = 1'b0;
`ifdef AUDIO_DAC_MIDSCALE_PARK_EN
        exp_q.push_back(16'h3800); exp_frames++;
`endif
        wait_idle("disable");
        check_frames("disable");
        @(posedge clk); #1 bus.enable = 1'b1;
        repeat (4) @(negedge clk);
        check("reenable_busy", 32'(bus.busy), 32'd0);

        // Sustained stream at a random sample rate slower than a frame.
        min_gap = 1 << 30;
        for (int s = 0; s < 40; s++) begin
            v = 8'($urandom);
            pulse_strobe(v);
            exp_q.push_back(frame_of(v)); exp_frames++;
            repeat (int'($urandom_range(150, 300))) @(posedge clk);
        end
        wait_idle("stream");
        check_frames("stream");
        check("stream_min_gap", 32'(min_gap >= GAP_CYCLES), 32'd1);

        // Frame counter wrap.
        @(posedge clk);
        force dut.r_frames_sent = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_frames_sent;
        exp_frames = 16'hFFFF;
        @(negedge clk);
        check("wrap_preload", 32'(bus.frames_sent), 32'h0000FFFF);
        v = 8'($urandom);
        pulse_strobe(v);
        exp_q.push_back(frame_of(v)); exp_frames++;
        wait_idle("wrap");
        check_frames("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
